// File: rtl/lsu_dccm_arb_if.sv
// lsu_dccm_arb_if: bus bundle between the LSU pipe, the DMA slave port,
// the DCCM arbiter and the DCCM macro.
//   slave  : arbiter side (takes LSU/DMA requests, drives the DCCM, returns reads)
//   master : environment side (requesters and DCCM model)
// Groups: lsu_* request/ready/read-return, dma_* request/ready/response,
//         dccm_* single-port access plus read data (valid 1 cycle after rden).
interface lsu_dccm_arb_if #(
  parameter int DCCM_BITS  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DMA_TAG_W  = 3
);
  logic                    lsu_req_valid;
  logic                    lsu_req_wr;
  logic [DCCM_BITS-1:0]    lsu_addr;
  logic [DATA_WIDTH-1:0]   lsu_wdata;
  logic                    lsu_ready;
  logic                    lsu_rd_valid;
  logic [DATA_WIDTH-1:0]   lsu_rd_data;

  logic                    dma_req_valid;
  logic                    dma_req_wr;
  logic [DCCM_BITS-1:0]    dma_addr;
  logic [DATA_WIDTH-1:0]   dma_wdata;
  logic [DATA_WIDTH/8-1:0] dma_byteen;
  logic [DMA_TAG_W-1:0]    dma_tag;
  logic                    dma_ready;
  logic                    dma_rsp_valid;
  logic [DATA_WIDTH-1:0]   dma_rsp_data;
  logic [DMA_TAG_W-1:0]    dma_rsp_tag;

  logic                    dccm_wren;
  logic                    dccm_rden;
  logic [DCCM_BITS-1:0]    dccm_addr;
  logic [DATA_WIDTH-1:0]   dccm_wr_data;
  logic [DATA_WIDTH-1:0]   dccm_rd_data;

  modport slave (
    input  lsu_req_valid, lsu_req_wr, lsu_addr, lsu_wdata,
    output lsu_ready, lsu_rd_valid, lsu_rd_data,
    input  dma_req_valid, dma_req_wr, dma_addr, dma_wdata, dma_byteen, dma_tag,
    output dma_ready, dma_rsp_valid, dma_rsp_data, dma_rsp_tag,
    output dccm_wren, dccm_rden, dccm_addr, dccm_wr_data,
    input  dccm_rd_data
  );

  modport master (
    output lsu_req_valid, lsu_req_wr, lsu_addr, lsu_wdata,
    input  lsu_ready, lsu_rd_valid, lsu_rd_data,
    output dma_req_valid, dma_req_wr, dma_addr, dma_wdata, dma_byteen, dma_tag,
    input  dma_ready, dma_rsp_valid, dma_rsp_data, dma_rsp_tag,
    input  dccm_wren, dccm_rden, dccm_addr, dccm_wr_data,
    output dccm_rd_data
  );
endinterface

// File: rtl/lsu_dccm_arb.sv
// lsu_dccm_arb: single-port DCCM arbiter between the LSU pipe and DMA.
// LSU has fixed priority; after DMA_STALL_MAX consecutive blocked cycles
// DMA is forced ahead. One DCCM access per cycle, read data returned to
// the owning requester one cycle after issue.
// Ports: clk, rst (sync, active-high), bus (lsu_dccm_arb_if.slave).
// Optional: define LSU_DCCM_ARB_RMW_EN to run partial DMA writes as a
// read-modify-write (IDLE -> RMW_WR -> IDLE). Without it, dma_byteen is
// ignored and every DMA write is a full-word write.
module lsu_dccm_arb #(
  parameter int DCCM_BITS     = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DMA_TAG_W     = 3,
  parameter int DMA_STALL_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  lsu_dccm_arb_if.slave  bus
);
  localparam int BE_W  = DATA_WIDTH/8;
  localparam int CNT_W = $clog2(DMA_STALL_MAX+1);

`ifdef LSU_DCCM_ARB_RMW_EN
  typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_e;
`else
  typedef enum logic [0:0] {IDLE = 1'b0} state_e;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  dma_force, dma_win, lsu_win, dma_rmw;
  logic                  wren_c, rden_c;
  logic [DCCM_BITS-1:0]  addr_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic                  rd_vld, rd_dma;
  logic [DMA_TAG_W-1:0]  rd_tag;

`ifdef LSU_DCCM_ARB_RMW_EN
  logic [DCCM_BITS-1:0]  rmw_addr;
  logic [DATA_WIDTH-1:0] rmw_wdata, rmw_merged;
  logic [BE_W-1:0]       rmw_byteen;

  // Enabled bytes come from the latched DMA data, the rest from the old word.
  for (genvar b = 0; b < BE_W; b++) begin : g_merge
    assign rmw_merged[b*8 +: 8] = rmw_byteen[b] ? rmw_wdata[b*8 +: 8]
                                                : bus.dccm_rd_data[b*8 +: 8];
  end
`else
  logic unused_byteen;
  assign unused_byteen = ^bus.dma_byteen;
`endif

  assign dma_force = (starve_cnt == CNT_W'(DMA_STALL_MAX));

  always_comb begin
    state_d = state_q;
    dma_win = 1'b0;
    lsu_win = 1'b0;
    dma_rmw = 1'b0;
    wren_c  = 1'b0;
    rden_c  = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    case (state_q)
      IDLE: begin
        dma_win = bus.dma_req_valid & (~bus.lsu_req_valid | dma_force);
        lsu_win = bus.lsu_req_valid & ~dma_win;
        if (dma_win) begin
`ifdef LSU_DCCM_ARB_RMW_EN
          dma_rmw = bus.dma_req_wr & (bus.dma_byteen != {BE_W{1'b1}});
`endif
          addr_c  = bus.dma_addr;
          wdata_c = bus.dma_wdata;
          wren_c  = bus.dma_req_wr & ~dma_rmw;
          rden_c  = ~bus.dma_req_wr | dma_rmw;
`ifdef LSU_DCCM_ARB_RMW_EN
          if (dma_rmw) state_d = RMW_WR;
`endif
        end else if (lsu_win) begin
          addr_c  = bus.lsu_addr;
          wdata_c = bus.lsu_wdata;
          wren_c  = bus.lsu_req_wr;
          rden_c  = ~bus.lsu_req_wr;
        end
      end
`ifdef LSU_DCCM_ARB_RMW_EN
      RMW_WR: begin
        wren_c  = 1'b1;
        addr_c  = rmw_addr;
        wdata_c = rmw_merged;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Handshake and enables are forced low while reset is held.
  assign bus.lsu_ready     = lsu_win & ~rst;
  assign bus.dma_ready     = dma_win & ~rst;
  assign bus.dccm_wren     = wren_c & ~rst;
  assign bus.dccm_rden     = rden_c & ~rst;
  assign bus.dccm_addr     = addr_c;
  assign bus.dccm_wr_data  = wdata_c;
  assign bus.lsu_rd_valid  = rd_vld & ~rd_dma & ~rst;
  assign bus.lsu_rd_data   = bus.dccm_rd_data;
  assign bus.dma_rsp_valid = rd_vld & rd_dma & ~rst;
  assign bus.dma_rsp_data  = bus.dccm_rd_data;
  assign bus.dma_rsp_tag   = rd_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_cnt <= '0;
      rd_vld     <= 1'b0;
      rd_dma     <= 1'b0;
      rd_tag     <= '0;
    end else begin
      state_q <= state_d;
      // Held during the RMW write beat; otherwise counts blocked DMA cycles.
      if (state_q == IDLE) begin
        if (!bus.dma_req_valid || dma_win) starve_cnt <= '0;
        else if (!dma_force)              starve_cnt <= starve_cnt + 1'b1;
      end
      // The RMW read phase is internal and never returns a response.
      rd_vld <= rden_c & ~dma_rmw;
      rd_dma <= dma_win;
      if (dma_win) rd_tag <= bus.dma_tag;
    end
  end

`ifdef LSU_DCCM_ARB_RMW_EN
  always_ff @(posedge clk) begin
    if (dma_rmw) begin
      rmw_addr   <= bus.dma_addr;
      rmw_wdata  <= bus.dma_wdata;
      rmw_byteen <= bus.dma_byteen;
    end
  end
`endif
endmodule

// File: tb/tb_lsu_dccm_arb.sv
// tb_lsu_dccm_arb: directed bench for lsu_dccm_arb with a 1-cycle-latency
// DCCM model. Inputs change 1 time unit after posedge, outputs are checked
// at negedge. The RMW scenario runs only when LSU_DCCM_ARB_RMW_EN is defined.
module tb_lsu_dccm_arb;
  localparam int DB = 16, DW = 32, TW = 3;

  localparam logic [31:0] D10 = 32'hCAFE_0010;
  localparam logic [31:0] D20 = 32'h1234_0020;
  localparam logic [31:0] D40 = 32'hBEEF_0040;
  localparam logic [31:0] D08 = 32'hAABB_CCDD;

  logic clk, rst;
  int nvec, nerr;

  lsu_dccm_arb_if #(.DCCM_BITS(DB), .DATA_WIDTH(DW), .DMA_TAG_W(TW)) bus ();

  lsu_dccm_arb #(.DCCM_BITS(DB), .DATA_WIDTH(DW), .DMA_TAG_W(TW), .DMA_STALL_MAX(8))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // DCCM model: 64 words, read data registered one cycle after rden.
  logic [31:0] mem [64];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (bus.dccm_wren) mem[bus.dccm_addr[7:2]] <= bus.dccm_wr_data;
    if (bus.dccm_rden) rd_q <= mem[bus.dccm_addr[7:2]];
  end
  assign bus.dccm_rd_data = rd_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.lsu_req_valid = 0; bus.lsu_req_wr = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
    bus.dma_req_valid = 0; bus.dma_req_wr = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.dma_byteen = 4'hF; bus.dma_tag = '0;
  endtask

  task automatic lsu(input logic wr, input logic [15:0] a, input logic [31:0] d);
    bus.lsu_req_valid = 1; bus.lsu_req_wr = wr; bus.lsu_addr = a; bus.lsu_wdata = d;
  endtask

  task automatic dma(input logic wr, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [2:0] t);
    bus.dma_req_valid = 1; bus.dma_req_wr = wr; bus.dma_addr = a; bus.dma_wdata = d;
    bus.dma_byteen = be; bus.dma_tag = t;
  endtask

  task automatic test_reset();
    rst = 1; idle(); lsu(0, 16'h10, '0); dma(0, 16'h20, '0, 4'hF, 3'd1);
    cyc(); cyc(); @(negedge clk);
    nvec++; if ({bus.lsu_ready, bus.dma_ready, bus.dccm_wren, bus.dccm_rden,
                 bus.lsu_rd_valid, bus.dma_rsp_valid} !== 6'b0) begin
      nerr++; $display("FAIL reset_outputs: got %b want 000000", {bus.lsu_ready, bus.dma_ready,
        bus.dccm_wren, bus.dccm_rden, bus.lsu_rd_valid, bus.dma_rsp_valid});
    end
    nvec++; if (dut.starve_cnt !== 0) begin
      nerr++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt);
    end
    cyc(); rst = 0; idle();
    @(negedge clk);
    nvec++; if ({bus.lsu_ready, bus.dma_ready} !== 2'b00) begin
      nerr++; $display("FAIL ready_without_valid: got %b want 00", {bus.lsu_ready, bus.dma_ready});
    end
  endtask

  // Alternating LSU writes/reads; also preloads memory for later tests.
  task automatic test_back_to_back();
    logic [15:0] a [4];
    logic [31:0] d [4];
    a = '{16'h10, 16'h20, 16'h40, 16'h08};
    d = '{D10, D20, D40, D08};
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); lsu(1, a[i], d[i]);
      @(negedge clk);
      nvec++; if ({bus.lsu_ready, bus.dccm_wren, bus.dccm_rden, bus.dccm_addr} !== {3'b110, a[i]}) begin
        nerr++; $display("FAIL b2b_wr%0d: got rdy/wr/rd/addr %b/%b/%b/%h want 1/1/0/%h", i,
          bus.lsu_ready, bus.dccm_wren, bus.dccm_rden, bus.dccm_addr, a[i]);
      end
      cyc(); idle(); lsu(0, a[i], '0);
      @(negedge clk);
      nvec++; if ({bus.lsu_ready, bus.dccm_rden} !== 2'b11) begin
        nerr++; $display("FAIL b2b_rd%0d_issue: got %b want 11", i, {bus.lsu_ready, bus.dccm_rden});
      end
      cyc(); idle();
      @(negedge clk);
      nvec++; if (bus.lsu_rd_valid !== 1'b1 || bus.lsu_rd_data !== d[i]) begin
        nerr++; $display("FAIL b2b_rd%0d_data: got v=%b %h want v=1 %h", i,
          bus.lsu_rd_valid, bus.lsu_rd_data, d[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    cyc(); idle(); lsu(0, 16'h10, '0); dma(0, 16'h20, '0, 4'hF, 3'd1);
    @(negedge clk);
    nvec++; if ({bus.lsu_ready, bus.dma_ready, bus.dccm_rden, bus.dccm_addr} !== {3'b101, 16'h10}) begin
      nerr++; $display("FAIL same_cycle_grant: got l/d/rd/addr %b/%b/%b/%h want 1/0/1/0010",
        bus.lsu_ready, bus.dma_ready, bus.dccm_rden, bus.dccm_addr);
    end
    cyc(); bus.lsu_req_valid = 0;
    @(negedge clk);
    nvec++; if (bus.lsu_rd_valid !== 1'b1 || bus.lsu_rd_data !== D10 || bus.dma_rsp_valid !== 1'b0) begin
      nerr++; $display("FAIL same_cycle_lsu_ret: got v=%b %h dv=%b want v=1 %h dv=0",
        bus.lsu_rd_valid, bus.lsu_rd_data, bus.dma_rsp_valid, D10);
    end
    nvec++; if ({bus.dma_ready, bus.dccm_addr} !== {1'b1, 16'h20}) begin
      nerr++; $display("FAIL same_cycle_dma_grant: got %b/%h want 1/0020", bus.dma_ready, bus.dccm_addr);
    end
    cyc(); idle();
    @(negedge clk);
    nvec++; if ({bus.dma_rsp_valid, bus.lsu_rd_valid, bus.dma_rsp_tag} !== {2'b10, 3'd1}
                || bus.dma_rsp_data !== D20) begin
      nerr++; $display("FAIL same_cycle_dma_ret: got v=%b lv=%b tag=%0d %h want 1/0/1 %h",
        bus.dma_rsp_valid, bus.lsu_rd_valid, bus.dma_rsp_tag, bus.dma_rsp_data, D20);
    end
  endtask

  task automatic test_dma_read();
    cyc(); idle(); dma(0, 16'h40, '0, 4'hF, 3'd5);
    @(negedge clk);
    nvec++; if ({bus.dma_ready, bus.lsu_ready, bus.dccm_rden} !== 3'b101) begin
      nerr++; $display("FAIL dma_rd_grant: got %b want 101", {bus.dma_ready, bus.lsu_ready, bus.dccm_rden});
    end
    cyc(); idle();
    @(negedge clk);
    nvec++; if (bus.dma_rsp_valid !== 1'b1 || bus.dma_rsp_tag !== 3'd5 || bus.dma_rsp_data !== D40) begin
      nerr++; $display("FAIL dma_rd_rsp: got v=%b tag=%0d %h want v=1 tag=5 %h",
        bus.dma_rsp_valid, bus.dma_rsp_tag, bus.dma_rsp_data, D40);
    end
  endtask

  task automatic test_starvation();
    for (int k = 1; k <= 9; k++) begin
      cyc(); idle(); lsu(0, 16'h10, '0); dma(0, 16'h20, '0, 4'hF, 3'd2);
      @(negedge clk);
      nvec++;
      if (k < 9 && {bus.lsu_ready, bus.dma_ready} !== 2'b10) begin
        nerr++; $display("FAIL starve_block_c%0d: got l/d %b want 10", k, {bus.lsu_ready, bus.dma_ready});
      end else if (k == 9 && {bus.lsu_ready, bus.dma_ready} !== 2'b01) begin
        nerr++; $display("FAIL starve_force_c9: got l/d %b want 01", {bus.lsu_ready, bus.dma_ready});
      end
    end
    cyc(); idle(); lsu(0, 16'h10, '0); dma(0, 16'h40, '0, 4'hF, 3'd3);
    @(negedge clk);
    nvec++; if ({bus.lsu_ready, bus.dma_ready} !== 2'b10 || dut.starve_cnt !== 0) begin
      nerr++; $display("FAIL starve_after: got l/d %b cnt=%0d want 10 cnt=0",
        {bus.lsu_ready, bus.dma_ready}, dut.starve_cnt);
    end
    nvec++; if (bus.dma_rsp_valid !== 1'b1 || bus.dma_rsp_tag !== 3'd2 || bus.dma_rsp_data !== D20) begin
      nerr++; $display("FAIL starve_rsp: got v=%b tag=%0d %h want 1/2 %h",
        bus.dma_rsp_valid, bus.dma_rsp_tag, bus.dma_rsp_data, D20);
    end
    cyc(); idle();
    @(negedge clk);
    nvec++; if (bus.lsu_rd_valid !== 1'b1 || bus.lsu_rd_data !== D10) begin
      nerr++; $display("FAIL starve_lsu_ret: got v=%b %h want 1 %h", bus.lsu_rd_valid, bus.lsu_rd_data, D10);
    end
  endtask

`ifdef LSU_DCCM_ARB_RMW_EN
  task automatic test_partial_write();
    cyc(); idle(); dma(1, 16'h08, 32'h1122_3344, 4'b0101, 3'd4);
    @(negedge clk);
    nvec++; if ({bus.dma_ready, bus.dccm_rden, bus.dccm_wren, bus.dccm_addr} !== {3'b110, 16'h08}) begin
      nerr++; $display("FAIL rmw_c0: got rdy/rd/wr/addr %b/%b/%b/%h want 1/1/0/0008",
        bus.dma_ready, bus.dccm_rden, bus.dccm_wren, bus.dccm_addr);
    end
    cyc(); idle(); lsu(0, 16'h08, '0);
    @(negedge clk);
    nvec++; if ({bus.lsu_ready, bus.dma_ready, bus.dccm_wren, bus.dccm_addr} !== {3'b001, 16'h08}
                || bus.dccm_wr_data !== 32'hAA22_CC44) begin
      nerr++; $display("FAIL rmw_c1: got l/d/wr/addr %b/%b/%b/%h data %h want 0/0/1/0008 aa22cc44",
        bus.lsu_ready, bus.dma_ready, bus.dccm_wren, bus.dccm_addr, bus.dccm_wr_data);
    end
    nvec++; if ({bus.lsu_rd_valid, bus.dma_rsp_valid} !== 2'b00) begin
      nerr++; $display("FAIL rmw_c1_rsp: got %b want 00", {bus.lsu_rd_valid, bus.dma_rsp_valid});
    end
    cyc();
    @(negedge clk);
    nvec++; if (bus.lsu_ready !== 1'b1) begin
      nerr++; $display("FAIL rmw_c2_lsu: got %b want 1", bus.lsu_ready);
    end
    cyc(); idle();
    @(negedge clk);
    nvec++; if (bus.lsu_rd_valid !== 1'b1 || bus.lsu_rd_data !== 32'hAA22_CC44) begin
      nerr++; $display("FAIL rmw_readback: got v=%b %h want 1 aa22cc44", bus.lsu_rd_valid, bus.lsu_rd_data);
    end
  endtask
`else
  task automatic test_full_dma_write();
    cyc(); idle(); dma(1, 16'h08, 32'h1122_3344, 4'hF, 3'd4);
    @(negedge clk);
    nvec++; if ({bus.dma_ready, bus.dccm_wren, bus.dccm_rden, bus.dccm_addr} !== {3'b110, 16'h08}
                || bus.dccm_wr_data !== 32'h1122_3344) begin
      nerr++; $display("FAIL dma_wr: got rdy/wr/rd/addr %b/%b/%b/%h data %h want 1/1/0/0008 11223344",
        bus.dma_ready, bus.dccm_wren, bus.dccm_rden, bus.dccm_addr, bus.dccm_wr_data);
    end
    cyc(); idle(); lsu(0, 16'h08, '0);
    @(negedge clk);
    nvec++; if ({bus.lsu_ready, bus.dma_rsp_valid} !== 2'b10) begin
      nerr++; $display("FAIL dma_wr_next: got l/dv %b want 10", {bus.lsu_ready, bus.dma_rsp_valid});
    end
    cyc(); idle();
    @(negedge clk);
    nvec++; if (bus.lsu_rd_valid !== 1'b1 || bus.lsu_rd_data !== 32'h1122_3344) begin
      nerr++; $display("FAIL dma_wr_readback: got v=%b %h want 1 11223344", bus.lsu_rd_valid, bus.lsu_rd_data);
    end
  endtask
`endif

  task automatic test_reset_mid();
    cyc(); idle(); lsu(0, 16'h10, '0);
    @(negedge clk);
    nvec++; if (bus.lsu_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_mid_grant: got %b want 1", bus.lsu_ready);
    end
    cyc(); idle(); rst = 1;
    @(negedge clk);
    nvec++; if ({bus.lsu_rd_valid, bus.dma_rsp_valid} !== 2'b00) begin
      nerr++; $display("FAIL rst_mid_rsp: got %b want 00", {bus.lsu_rd_valid, bus.dma_rsp_valid});
    end
    cyc(); rst = 0;
    @(negedge clk);
    nvec++; if ({bus.lsu_ready, bus.dma_ready, bus.dccm_wren, bus.dccm_rden,
                 bus.lsu_rd_valid, bus.dma_rsp_valid} !== 6'b0) begin
      nerr++; $display("FAIL rst_mid_after: got %b want 000000", {bus.lsu_ready, bus.dma_ready,
        bus.dccm_wren, bus.dccm_rden, bus.lsu_rd_valid, bus.dma_rsp_valid});
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst = 1; idle();
    test_reset();
    test_back_to_back();
    test_same_cycle();
    test_dma_read();
    test_starvation();
`ifdef LSU_DCCM_ARB_RMW_EN
    test_partial_write();
`else
    test_full_dma_write();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
